// File: rtl/ysyx_22040759_div.sv
// Multi-cycle restoring divider for RV64M div/divu/rem/remu and the W variants.
// Quotient and remainder are returned together after N+1 cycles (N = 64 or 32).
module ysyx_22040759_div #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_signed,
    input  logic             div_word,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high and flush is low; valid never depends on ready, and results hold until taken.
    localparam int W    = WIDTH;
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH) + 1;

    localparam logic [CW-1:0] N_FULL  = CW'(W);
    localparam logic [CW-1:0] N_WORD  = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SPECIAL = 2'd1,
        S_CALC    = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e          state_q;
    logic            div_ready_q;
    logic            out_valid_q;
    logic [W-1:0]    quotient_q;
    logic [W-1:0]    remainder_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    a_raw_q;
    logic [W-1:0]    div_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;
    logic            word_q;
    logic            dz_q;
    logic            neg_quo_q;
    logic            neg_rem_q;

    logic [W-1:0]    a_ext;
    logic [W-1:0]    b_ext;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic            ovf;

    logic [W:0]      r_shift;
    logic [W:0]      r_sub;
    logic [W-1:0]    rem_step_d;
    logic [W-1:0]    quo_step_d;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;
    logic [W-1:0]    quo_fin_d;
    logic [W-1:0]    rem_fin_d;
    logic [W-1:0]    a_sx;
    logic [W-1:0]    spec_quo_d;
    logic [W-1:0]    spec_rem_d;

    // Operand preparation straight from the request inputs; only used on the accepting edge.
    always_comb begin
        a_ext = dividend;
        b_ext = divisor;
        if (div_word) begin
            a_ext = div_signed ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]}
                               : {{HALF{1'b0}}, dividend[HALF-1:0]};
            b_ext = div_signed ? {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]}
                               : {{HALF{1'b0}}, divisor[HALF-1:0]};
        end
        a_neg  = div_signed & a_ext[W-1];
        b_neg  = div_signed & b_ext[W-1];
        a_mag  = a_neg ? -a_ext : a_ext;
        b_mag  = b_neg ? -b_ext : b_ext;
        b_zero = (b_ext == '0);
        ovf    = div_signed & (b_ext == '1) &
                 (div_word ? (dividend[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                           : (dividend == {1'b1, {(W-1){1'b0}}}));
    end

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    always_comb begin
        r_shift = {rem_q, quo_q[W-1]};
        r_sub   = r_shift - {1'b0, div_q};
        if (!r_sub[W]) begin
            rem_step_d = r_sub[W-1:0];
            quo_step_d = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_step_d = r_shift[W-1:0];
            quo_step_d = {quo_q[W-2:0], 1'b0};
        end
        quo_fix   = neg_quo_q ? -quo_step_d : quo_step_d;
        rem_fix   = neg_rem_q ? -rem_step_d : rem_step_d;
        quo_fin_d = word_q ? {{HALF{quo_fix[HALF-1]}}, quo_fix[HALF-1:0]} : quo_fix;
        rem_fin_d = word_q ? {{HALF{rem_fix[HALF-1]}}, rem_fix[HALF-1:0]} : rem_fix;
    end

    // Divide-by-zero and signed overflow both hand back the (width-adjusted) dividend.
    always_comb begin
        a_sx       = word_q ? {{HALF{a_raw_q[HALF-1]}}, a_raw_q[HALF-1:0]} : a_raw_q;
        spec_quo_d = dz_q ? '1 : a_sx;
        spec_rem_d = dz_q ? a_sx : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            cnt_q       <= '0;
            a_raw_q     <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            word_q      <= 1'b0;
            dz_q        <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            div_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_valid) begin
                        a_raw_q     <= dividend;
                        word_q      <= div_word;
                        dz_q        <= b_zero;
                        neg_quo_q   <= a_neg ^ b_neg;
                        neg_rem_q   <= a_neg;
                        div_q       <= b_mag;
                        rem_q       <= '0;
                        quo_q       <= div_word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                        cnt_q       <= div_word ? N_WORD : N_FULL;
                        div_ready_q <= 1'b0;
                        state_q     <= (b_zero || ovf) ? S_SPECIAL : S_CALC;
                    end
                end
                S_SPECIAL: begin
                    quotient_q  <= spec_quo_d;
                    remainder_q <= spec_rem_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_CALC: begin
                    rem_q <= rem_step_d;
                    quo_q <= quo_step_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        quotient_q  <= quo_fin_d;
                        remainder_q <= rem_fin_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        div_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    div_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_ready   = div_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_22040759_div.sv
// Self-checking bench for ysyx_22040759_div: directed RV64M cases, backpressure,
// flush/reset aborts and random operands against a plain-arithmetic reference model.
module tb_ysyx_22040759_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid;
    logic        div_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_signed;
    logic        div_word;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    ysyx_22040759_div #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_signed (div_signed),
        .div_word   (div_word),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results from ordinary signed/unsigned arithmetic plus the RISC-V special cases.
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic s, input logic w);
        logic [63:0] q, r;
        logic [31:0] a32, b32, q32, r32;
        int          sa, sb;
        longint      la, lb;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            sa  = a32;
            sb  = b32;
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (s) begin
                q32 = sa / sb;
                r32 = sa % sb;
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            la = a;
            lb = b;
            if (b == 64'd0) begin
                q = '1;
                r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a;
                r = 64'd0;
            end else if (s) begin
                q = la / lb;
                r = la % lb;
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        return {q, r};
    endfunction

    // Clocks from the accepting edge (counted as 1) to the edge that raises out_valid.
    function automatic int lat_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic s, input logic w);
        bit special;
        if (w) special = (b[31:0] == 32'd0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else   special = (b == 64'd0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
        if (special) return 2;
        return w ? 33 : 65;
    endfunction

    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                            input string tag);
        check({tag, "_rdy_idle"}, 64'(div_ready), 64'd1);
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_word   = w;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        dividend   = {$urandom, $urandom};
        divisor    = {$urandom, $urandom};
        div_signed = 1'($urandom_range(0, 1));
        div_word   = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                          input int hold, input string tag);
        logic [127:0] m;
        logic [63:0]  eq, er;
        int           lat;
        bit           rdy_seen;
        m = model(a, b, s, w);
        exp_q.push_back(m[127:64]);
        exp_q.push_back(m[63:0]);
        start_op(a, b, s, w, tag);
        lat = 1;
        rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (div_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        check({tag, "_lat"}, 64'(lat), 64'(lat_model(a, b, s, w)));
        check({tag, "_rdy_busy"}, 64'(rdy_seen), 64'd0);
        check({tag, "_quo"}, quotient, eq);
        check({tag, "_rem"}, remainder, er);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_rdy"}, 64'(div_ready), 64'd0);
            check({tag, "_hold_quo"}, quotient, eq);
            check({tag, "_hold_rem"}, remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_back_rdy"}, 64'(div_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic        rs, rw;
        int          sel;
        bit          seen;

        rst        = 1'b1;
        div_valid  = 1'b0;
        dividend   = '0;
        divisor    = '0;
        div_signed = 1'b0;
        div_word   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 64'(div_ready), 64'd1);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_quo", quotient, 64'd0);
        check("reset_rem", remainder, 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(64'd100, 64'd7, 1'b0, 1'b0, 0, "divu_100_7");
        run_op(-64'sd7, 64'd2, 1'b1, 1'b0, 0, "div_m7_2");
        run_op(64'd7, -64'sd2, 1'b1, 1'b0, 0, "div_7_m2");
        run_op(64'h1234, 64'd0, 1'b0, 1'b0, 0, "div_by_zero");
        run_op(64'h1234, 64'd0, 1'b1, 1'b1, 0, "divw_by_zero");
        run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 0, "div_ovf");
        run_op(64'h0000_0001_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 0, "divuw_1");
        run_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 0, "divw_ovf");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 0, "divu_max_3");

        run_op(64'd1000, 64'd33, 1'b1, 1'b0, 10, "backpressure");
        run_op(64'hDEAD_BEEF_0123_4567, 64'h1_0001, 1'b0, 1'b0, 0, "back_to_back");

        // Kill an operation just before CALC step 20.
        start_op(64'd5000, 64'd3, 1'b0, 1'b0, "flush_op");
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_rdy", 64'(div_ready), 64'd1);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_state", 64'(dbg_state), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        dividend  = 64'd9;
        divisor   = 64'd3;
        div_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        flush     = 1'b0;
        check("flush_blocks_accept_rdy", 64'(div_ready), 64'd1);
        check("flush_blocks_accept_state", 64'(dbg_state), 64'd0);

        run_op(64'd5000, 64'd3, 1'b0, 1'b0, 0, "after_flush");

        start_op(64'd77777, 64'd11, 1'b0, 1'b0, "reset_op");
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_rdy", 64'(div_ready), 64'd1);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_quo", quotient, 64'd0);
        check("midrst_rem", remainder, 64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);

        run_op(64'd77777, 64'd11, 1'b0, 1'b0, 0, "after_reset");

        for (int i = 0; i < 24; i++) begin
            rs  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            if (rw) rb = {$urandom, $urandom >> $urandom_range(0, 31)};
            else    rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                rb = rw ? {$urandom, 32'd0} : 64'd0;
            end else if (sel == 1) begin
                rs = 1'b1;
                ra = rw ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                rb = rw ? {$urandom, 32'hFFFF_FFFF} : '1;
            end
            run_op(ra, rb, rs, rw, $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
